vga_frame_reader: RTL and testbench

- Display-side consumer of the SPRAM frame buffer. Generates 640x480 VGA timing, presents the 19-bit read address of each active pixel to the frame-buffer controller, and samples the returned 2-bit pixel.
- Converts each 2-bit pixel to 4-bit-per-channel greyscale with sync and blanking. Sits between the frame-buffer controller and the board VGA pins.

---
 rtl/vga_frame_reader_if.sv | 22 ++
 rtl/vga_frame_reader.sv | 111 +++++++++++
 tb/tb_vga_frame_reader.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_frame_reader_if.sv
// Frame-buffer read port between the display reader and the frame-buffer controller.
// The reader (master) owns the address; the controller (slave) returns the pixel
// and a strobe marking the cycle on which that pixel is valid.
interface vga_frame_reader_if #(
  parameter int unsigned ADDR_W = 19
);
  logic              pixelEn;
  logic [1:0]        pixelData;
  logic [ADDR_W-1:0] addressRead;

  modport master (
    input  pixelEn,
    input  pixelData,
    output addressRead
  );

  modport slave (
    output pixelEn,
    output pixelData,
    input  addressRead
  );
endinterface

// File: rtl/vga_frame_reader.sv
// VGA frame reader: walks the frame in raster order, one position per pixel strobe,
// presents the linear frame-buffer address of the current (or next) active pixel and
// turns the returned 2-bit pixel into 4-bit greyscale with sync and display enable.
// All video outputs lag the counter position by exactly one strobe.
module vga_frame_reader #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter bit          SYNC_ACTIVE = 1'b0,
  parameter int unsigned ADDR_W      = 19
) (
  input  logic                mainClk,
  input  logic                nreset,
  vga_frame_reader_if.master  fb,
  output logic                hsync,
  output logic                vsync,
  output logic                de,
  output logic [3:0]          red,
  output logic [3:0]          green,
  output logic [3:0]          blue,
  output logic                frameStart
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] HActive     = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HActiveLast = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] HLast       = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HSyncStart  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HSyncEnd    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VActive     = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VActiveLast = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VLast       = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VSyncStart  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VSyncEnd    = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0]     hCount, hCountNext;
  logic [VW-1:0]     vCount, vCountNext;
  logic [ADDR_W-1:0] address, addressNext;
  logic [3:0]        grey, greyNext;
  logic              active, lineEnd, frameEnd;
  logic              hsyncNext, vsyncNext;

  assign fb.addressRead = address;
  assign red   = grey;
  assign green = grey;
  assign blue  = grey;

  // Next raster position, next address and the video values for the current position.
  always_comb begin
    active   = (hCount < HActive) && (vCount < VActive);
    lineEnd  = (hCount == HLast);
    frameEnd = lineEnd && (vCount == VLast);

    hCountNext = lineEnd ? '0 : hCount + 1'b1;
    vCountNext = vCount;
    if (lineEnd) begin
      vCountNext = (vCount == VLast) ? '0 : vCount + 1'b1;
    end

    // Incremental address: steps only across active pixels, so during blanking it
    // already points at the first pixel of the next line (or 0 after the last line).
    addressNext = address;
    if (active) begin
      if ((hCount == HActiveLast) && (vCount == VActiveLast)) begin
        addressNext = '0;
      end else begin
        addressNext = address + 1'b1;
      end
    end

    hsyncNext = ((hCount >= HSyncStart) && (hCount < HSyncEnd)) ? SYNC_ACTIVE : !SYNC_ACTIVE;
    vsyncNext = ((vCount >= VSyncStart) && (vCount < VSyncEnd)) ? SYNC_ACTIVE : !SYNC_ACTIVE;
    greyNext  = active ? {fb.pixelData, fb.pixelData} : 4'h0;
  end

  // Counters, address and output registers; everything but frameStart moves only on a strobe.
  always_ff @(posedge mainClk) begin
    if (!nreset) begin
      hCount     <= '0;
      vCount     <= '0;
      address    <= '0;
      hsync      <= !SYNC_ACTIVE;
      vsync      <= !SYNC_ACTIVE;
      de         <= 1'b0;
      grey       <= 4'h0;
      frameStart <= 1'b0;
    end else begin
      // One-cycle pulse even when the strobe is held high.
      frameStart <= fb.pixelEn && frameEnd;
      if (fb.pixelEn) begin
        hCount  <= hCountNext;
        vCount  <= vCountNext;
        address <= addressNext;
        hsync   <= hsyncNext;
        vsync   <= vsyncNext;
        de      <= active;
        grey    <= greyNext;
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
module tb_vga_frame_reader;

  logic mainClk = 1'b0;
  logic nreset;
  always #5 mainClk = ~mainClk;

  // Full-size instance.
  vga_frame_reader_if fbBus ();
  logic hsync, vsync, de, frameStart;
  logic [3:0] red, green, blue;

  vga_frame_reader dut (
    .mainClk    (mainClk),
    .nreset     (nreset),
    .fb         (fbBus),
    .hsync      (hsync),
    .vsync      (vsync),
    .de         (de),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .frameStart (frameStart)
  );

  // Shrunken-timing instance (16 x 10 positions, 8 x 6 active) for frame-level checks.
  vga_frame_reader_if fbBusS ();
  logic hsyncS, vsyncS, deS, frameStartS;
  logic [3:0] redS, greenS, blueS;

  vga_frame_reader #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (1)
  ) dutS (
    .mainClk    (mainClk),
    .nreset     (nreset),
    .fb         (fbBusS),
    .hsync      (hsyncS),
    .vsync      (vsyncS),
    .de         (deS),
    .red        (redS),
    .green      (greenS),
    .blue       (blueS),
    .frameStart (frameStartS)
  );

  int total  = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Advance one clock; inputs are driven right after this returns, outputs sampled here.
  task automatic step();
    @(posedge mainClk);
    #1;
  endtask

  task automatic chkRgb(input string nm, input logic [3:0] exp);
    chk({nm, "_red"}, {28'd0, red}, {28'd0, exp});
    chk({nm, "_green"}, {28'd0, green}, {28'd0, exp});
    chk({nm, "_blue"}, {28'd0, blue}, {28'd0, exp});
  endtask

  typedef struct {
    logic       en;
    logic [1:0] data;
    logic       expDe;
    logic       expHs;
    logic [3:0] expRgb;
    int         expAddr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n, s, firstLow, lowCount, cnt, pulses;
    logic lastHs;

    // Colour map and hold, starting from (0,0) after reset.
    vecs[0] = '{1'b1, 2'd0, 1'b1, 1'b1, 4'h0, 1};
    vecs[1] = '{1'b1, 2'd1, 1'b1, 1'b1, 4'h5, 2};
    vecs[2] = '{1'b0, 2'd3, 1'b1, 1'b1, 4'h5, 2};
    vecs[3] = '{1'b1, 2'd2, 1'b1, 1'b1, 4'hA, 3};
    vecs[4] = '{1'b1, 2'd3, 1'b1, 1'b1, 4'hF, 4};
    vecs[5] = '{1'b0, 2'd0, 1'b1, 1'b1, 4'hF, 4};

    // Reset with strobe held high.
    nreset = 1'b0;
    fbBus.pixelEn = 1'b1;  fbBus.pixelData = 2'd3;
    fbBusS.pixelEn = 1'b0; fbBusS.pixelData = 2'd2;
    repeat (3) step();
    chk("rst_addr", {13'd0, fbBus.addressRead}, 32'd0);
    chk("rst_hsync", {31'd0, hsync}, 32'd1);
    chk("rst_vsync", {31'd0, vsync}, 32'd1);
    chk("rst_de", {31'd0, de}, 32'd0);
    chk("rst_fs", {31'd0, frameStart}, 32'd0);
    chkRgb("rst", 4'h0);

    // Released, no strobes: nothing moves.
    nreset = 1'b1;
    fbBus.pixelEn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_addr", {13'd0, fbBus.addressRead}, 32'd0);
      chk("idle_de", {31'd0, de}, 32'd0);
      chk("idle_sync", {30'd0, hsync, vsync}, 32'd3);
      chk("idle_rgb", {28'd0, red}, 32'd0);
    end

    // Table-driven colour map.
    foreach (vecs[i]) begin
      fbBus.pixelEn = vecs[i].en;
      fbBus.pixelData = vecs[i].data;
      step();
      chk($sformatf("vec%0d_de", i), {31'd0, de}, {31'd0, vecs[i].expDe});
      chk($sformatf("vec%0d_hs", i), {31'd0, hsync}, {31'd0, vecs[i].expHs});
      chkRgb($sformatf("vec%0d", i), vecs[i].expRgb);
      chk($sformatf("vec%0d_addr", i), {13'd0, fbBus.addressRead}, vecs[i].expAddr);
    end

    // Rest of line 0 with strobe held high.
    fbBus.pixelEn = 1'b1;
    fbBus.pixelData = 2'd1;
    for (n = 5; n <= 800; n++) begin
      step();
      chk($sformatf("line0_addr_n%0d", n), {13'd0, fbBus.addressRead},
          (n < 640) ? n : 640);
    end
    chk("line0_fs", {31'd0, frameStart}, 32'd0);

    // Line 1 with a strobe every 3rd cycle, pixelData=3 throughout.
    fbBus.pixelData = 2'd3;
    firstLow = 0; lowCount = 0; lastHs = hsync;
    for (s = 1; s <= 800; s++) begin
      fbBus.pixelEn = 1'b0;
      repeat (2) begin
        step();
        chk("hold_hsync", {31'd0, hsync}, {31'd0, lastHs});
      end
      fbBus.pixelEn = 1'b1;
      step();
      fbBus.pixelEn = 1'b0;
      lastHs = hsync;
      if (!hsync) begin
        lowCount++;
        if (firstLow == 0) firstLow = s;
      end
      chk($sformatf("l1_addr_s%0d", s), {13'd0, fbBus.addressRead},
          640 + ((s < 640) ? s : 640));
      if (s == 640 || s == 641 || s == 700) begin
        chk($sformatf("l1_de_s%0d", s), {31'd0, de}, (s <= 640) ? 32'd1 : 32'd0);
        chkRgb($sformatf("l1_s%0d", s), (s <= 640) ? 4'hF : 4'h0);
      end
    end
    chk("hsync_first_low", firstLow, 657);
    chk("hsync_low_count", lowCount, 96);
    chk("l1_vsync", {31'd0, vsync}, 32'd1);

    // Small instance: two full frames plus a little, strobe held high.
    fbBusS.pixelEn = 1'b1;
    pulses = 0;
    for (n = 1; n <= 373; n++) begin
      int q, hq, vq, p, h, v, ea;
      step();
      q = (n - 1) % 160; hq = q % 16; vq = q / 16;
      p = n % 160;       h = p % 16;  v = p / 16;
      if (v < 5 || (v == 5 && h < 8)) ea = v * 8 + ((h < 8) ? h : 8);
      else ea = 0;
      if (frameStartS) pulses++;
      chk($sformatf("s_fs_n%0d", n), {31'd0, frameStartS}, (p == 0) ? 32'd1 : 32'd0);
      chk($sformatf("s_addr_n%0d", n), {13'd0, fbBusS.addressRead}, ea);
      chk($sformatf("s_de_n%0d", n), {31'd0, deS}, (hq < 8 && vq < 6) ? 32'd1 : 32'd0);
      chk($sformatf("s_hs_n%0d", n), {31'd0, hsyncS}, (hq >= 10 && hq < 13) ? 32'd0 : 32'd1);
      chk($sformatf("s_vs_n%0d", n), {31'd0, vsyncS}, (vq >= 7 && vq < 9) ? 32'd0 : 32'd1);
      chk($sformatf("s_rgb_n%0d", n), {28'd0, redS}, (hq < 8 && vq < 6) ? 32'hA : 32'h0);
    end
    chk("s_pulses", pulses, 2);

    // Mid-frame reset at line 3, pixel 5 of the small instance.
    nreset = 1'b0;
    step();
    chk("mrst_addr", {13'd0, fbBusS.addressRead}, 32'd0);
    chk("mrst_sync", {30'd0, hsyncS, vsyncS}, 32'd3);
    chk("mrst_de", {31'd0, deS}, 32'd0);
    chk("mrst_rgb", {28'd0, redS}, 32'd0);
    chk("mrst_fs", {31'd0, frameStartS}, 32'd0);
    nreset = 1'b1;
    cnt = 0;
    while (cnt < 400) begin
      step();
      cnt++;
      if (cnt == 1) chk("mrst_addr_first", {13'd0, fbBusS.addressRead}, 32'd1);
      if (frameStartS) break;
    end
    chk("mrst_fs_strobes", cnt, 160);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
